// File: rtl/tube_pkg.sv
// rtl/tube_pkg.sv - shared types and constants for the Tube access sequencer
//
// Contents:
//   tube_state_e   : bus-cycle sequencer states
//   TUBE_BASE_ADR  : default match value for ADR[15:4] (&FA8x window)
//   CNT_W          : width of the phase-length down-counter
//   in_bus_cycle() : true while the Tube bus is owned (CS_B low)
package tube_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        DONE   = 3'd4
    } tube_state_e;

    localparam logic [11:0] TUBE_BASE_ADR = 12'hFA8;
    localparam int          CNT_W         = 4;

    // CS_B is low from the first SETUP cycle through the single HOLD cycle.
    function automatic logic in_bus_cycle(input tube_state_e s);
        return (s == SETUP) || (s == STROBE) || (s == HOLD);
    endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - generic two-flop synchroniser for a single asynchronous bit
//
// Ports:
//   clk     : destination clock
//   resetn  : synchronous active-low reset, loads RESET_VAL into both stages
//   d       : asynchronous input
//   q       : synchronised output (second stage)
module sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;
    logic meta_d;
    logic sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/tube_access_ctrl.sv
// rtl/tube_access_ctrl.sv - Z80 I/O window to 6502-style Tube bus cycle sequencer
//
// Turns a Z80 IN/OUT to the BASE_ADR window into one Tube cycle: CS_B low for
// PHI1_CYCLES of setup, PHI2 high for PHI2_HI_CYCLES, then one hold cycle.
// The Z80 is stretched with WAIT_B until the hold cycle has completed.
//
// Ports:
//   CLK, RESET_B            : clock, synchronous active-low reset
//   ADR, IOREQ_B, RD_B,
//   WR_B, M1_B, DATA_IN     : Z80 bus inputs (synchronous to CLK)
//   DATA_OUT, DATA_OE       : read data back to the Z80 and its drive enable
//   WAIT_B                  : Z80 wait request (combinational from decode)
//   INT_OE                  : open-drain enable for Z80 INT_B
//   TUBE_INT_B              : asynchronous Tube interrupt, active low
//   TUBE_ADR, TUBE_RNW,
//   TUBE_PHI2, TUBE_CS_B    : registered Tube control outputs
//   TUBE_DIN, TUBE_DOUT,
//   TUBE_DOE                : Tube data in, write data out and its drive enable
module tube_access_ctrl
    import tube_pkg::*;
#(
    parameter int          PHI1_CYCLES    = 2,
    parameter int          PHI2_HI_CYCLES = 2,
    parameter logic [11:0] BASE_ADR       = TUBE_BASE_ADR
) (
    input  logic        CLK,
    input  logic        RESET_B,
    input  logic [15:0] ADR,
    input  logic        IOREQ_B,
    input  logic        RD_B,
    input  logic        WR_B,
    input  logic        M1_B,
    input  logic [7:0]  DATA_IN,
    output logic [7:0]  DATA_OUT,
    output logic        DATA_OE,
    output logic        WAIT_B,
    output logic        INT_OE,
    input  logic        TUBE_INT_B,
    output logic [2:0]  TUBE_ADR,
    output logic        TUBE_RNW,
    output logic        TUBE_PHI2,
    output logic        TUBE_CS_B,
    input  logic [7:0]  TUBE_DIN,
    output logic [7:0]  TUBE_DOUT,
    output logic        TUBE_DOE
);

    localparam logic [CNT_W-1:0] PHI1_LOAD = CNT_W'(PHI1_CYCLES - 1);
    localparam logic [CNT_W-1:0] PHI2_LOAD = CNT_W'(PHI2_HI_CYCLES - 1);

    tube_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             armed_q, armed_d;
    logic             is_write_q, is_write_d;
    logic [2:0]       adr_q, adr_d;
    logic [7:0]       dout_q, dout_d;
    logic [7:0]       data_out_q, data_out_d;
    logic             phi2_q, phi2_d;
    logic             cs_b_q, cs_b_d;
    logic             rnw_q, rnw_d;
    logic             doe_q, doe_d;

    logic hit;
    logic int_sync;
    logic in_cycle_next;

    // ADR[3] is a don't-care: the 16-byte window mirrors the eight Tube registers.
    logic unused_adr3;
    assign unused_adr3 = ADR[3];

    // M1_B low with IOREQ_B low is an interrupt acknowledge and must never hit.
    assign hit = !IOREQ_B && M1_B && (ADR[15:4] == BASE_ADR) && (!RD_B || !WR_B);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_write_d = is_write_q;
        adr_d      = adr_q;
        dout_d     = dout_q;
        data_out_d = data_out_q;
        // Arming on any IOREQ_B-high sample ignores a cycle already in flight
        // when reset is released.
        armed_d    = armed_q || IOREQ_B;

        case (state_q)
            IDLE: begin
                if (hit && armed_q) begin
                    state_d    = SETUP;
                    adr_d      = ADR[2:0];
                    dout_d     = DATA_IN;
                    is_write_d = !WR_B;
                    cnt_d      = PHI1_LOAD;
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    state_d = STROBE;
                    cnt_d   = PHI2_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            STROBE: begin
                // Runs to completion regardless of IOREQ_B so PHI2 is never cut short.
                if (cnt_q == '0) begin
                    if (!is_write_q) begin
                        data_out_d = TUBE_DIN;
                    end
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HOLD: begin
                state_d = DONE;
            end
            DONE: begin
                if (IOREQ_B) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Tube control pins are decoded from the next state so they change
        // cleanly on the same edge as the state register.
        in_cycle_next = in_bus_cycle(state_d);
        phi2_d        = (state_d == STROBE);
        cs_b_d        = !in_cycle_next;
        rnw_d         = in_cycle_next ? !is_write_d : 1'b1;
        doe_d         = is_write_d && ((state_d == STROBE) || (state_d == HOLD));
    end

    always_ff @(posedge CLK) begin
        if (!RESET_B) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            armed_q    <= 1'b0;
            is_write_q <= 1'b0;
            adr_q      <= '0;
            dout_q     <= '0;
            data_out_q <= '0;
            phi2_q     <= 1'b0;
            cs_b_q     <= 1'b1;
            rnw_q      <= 1'b1;
            doe_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            armed_q    <= armed_d;
            is_write_q <= is_write_d;
            adr_q      <= adr_d;
            dout_q     <= dout_d;
            data_out_q <= data_out_d;
            phi2_q     <= phi2_d;
            cs_b_q     <= cs_b_d;
            rnw_q      <= rnw_d;
            doe_q      <= doe_d;
        end
    end

    // Idle level of TUBE_INT_B is high, so the synchroniser resets to 1.
    sync2 #(
        .RESET_VAL(1'b1)
    ) u_int_sync (
        .clk    (CLK),
        .resetn (RESET_B),
        .d      (TUBE_INT_B),
        .q      (int_sync)
    );

    // Combinational so the Z80 sees wait in the same cycle the decode appears;
    // released in the first DONE cycle.
    assign WAIT_B = !(hit && armed_q &&
                      ((state_q == IDLE) || (state_q == SETUP) ||
                       (state_q == STROBE) || (state_q == HOLD)));

    // Drops as soon as the Z80 releases RD_B or IOREQ_B to avoid bus contention.
    assign DATA_OE = !is_write_q && ((state_q == HOLD) || (state_q == DONE)) &&
                     !IOREQ_B && !RD_B;

    assign DATA_OUT  = data_out_q;
    assign INT_OE    = !int_sync;
    assign TUBE_ADR  = adr_q;
    assign TUBE_RNW  = rnw_q;
    assign TUBE_PHI2 = phi2_q;
    assign TUBE_CS_B = cs_b_q;
    assign TUBE_DOUT = dout_q;
    assign TUBE_DOE  = doe_q;

endmodule

// File: tb/tb_tube_access_ctrl.sv
// tb/tb_tube_access_ctrl.sv - self-checking bench for tube_access_ctrl
module tb_tube_access_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic [15:0] adr;
    logic        ioreq_b, rd_b, wr_b, m1_b;
    logic [7:0]  data_in, tube_din;
    logic        tube_int_b;

    logic [7:0]  data_out  [2];
    logic [2:0]  tube_adr  [2];
    logic [7:0]  tube_dout [2];
    logic [1:0]  data_oe, wait_b, int_oe, tube_rnw, tube_phi2, tube_cs_b, tube_doe;

    int tests_run    = 0;
    int tests_failed = 0;

    // Per-cycle trace of the watched instance: {cs_b, phi2, wait_b, rnw, doe, data_oe}
    logic [5:0] tr_ctl   [32];
    logic [2:0] tr_adr   [32];
    logic [7:0] tr_dout  [32];
    logic [7:0] tr_rdata [32];
    bit         tr_io    [32];

    always #5 clk = ~clk;

    tube_access_ctrl #(
        .PHI1_CYCLES(2), .PHI2_HI_CYCLES(2), .BASE_ADR(12'hFA8)
    ) u_dut0 (
        .CLK(clk), .RESET_B(resetn), .ADR(adr), .IOREQ_B(ioreq_b), .RD_B(rd_b),
        .WR_B(wr_b), .M1_B(m1_b), .DATA_IN(data_in), .DATA_OUT(data_out[0]),
        .DATA_OE(data_oe[0]), .WAIT_B(wait_b[0]), .INT_OE(int_oe[0]),
        .TUBE_INT_B(tube_int_b), .TUBE_ADR(tube_adr[0]), .TUBE_RNW(tube_rnw[0]),
        .TUBE_PHI2(tube_phi2[0]), .TUBE_CS_B(tube_cs_b[0]), .TUBE_DIN(tube_din),
        .TUBE_DOUT(tube_dout[0]), .TUBE_DOE(tube_doe[0])
    );

    tube_access_ctrl #(
        .PHI1_CYCLES(1), .PHI2_HI_CYCLES(4), .BASE_ADR(12'hFA8)
    ) u_dut1 (
        .CLK(clk), .RESET_B(resetn), .ADR(adr), .IOREQ_B(ioreq_b), .RD_B(rd_b),
        .WR_B(wr_b), .M1_B(m1_b), .DATA_IN(data_in), .DATA_OUT(data_out[1]),
        .DATA_OE(data_oe[1]), .WAIT_B(wait_b[1]), .INT_OE(int_oe[1]),
        .TUBE_INT_B(tube_int_b), .TUBE_ADR(tube_adr[1]), .TUBE_RNW(tube_rnw[1]),
        .TUBE_PHI2(tube_phi2[1]), .TUBE_CS_B(tube_cs_b[1]), .TUBE_DIN(tube_din),
        .TUBE_DOUT(tube_dout[1]), .TUBE_DOE(tube_doe[1])
    );

    task automatic sample(input int d, input int k);
        tr_ctl[k]   = {tube_cs_b[d], tube_phi2[d], wait_b[d], tube_rnw[d], tube_doe[d], data_oe[d]};
        tr_adr[k]   = tube_adr[d];
        tr_dout[k]  = tube_dout[d];
        tr_rdata[k] = data_out[d];
        tr_io[k]    = !ioreq_b;
    endtask

    // One Z80 I/O access watched on instance d. Called and returns at posedge+1.
    // The Z80 releases its strobes one cycle after it sees WAIT_B high (min 3 cycles),
    // then the bus stays idle for 'tail' cycles.
    task automatic run_access(input int d, input logic [15:0] a, input bit wr, input bit m1ack,
                              input logic [7:0] wd, input logic [7:0] td, input int tail,
                              input string name);
        int p1, p2, t, k, n;
        bit released, hit, in_cyc, e_doe;
        logic [5:0] e_ctl;
        p1  = (d == 0) ? 2 : 1;
        p2  = (d == 0) ? 2 : 4;
        t   = 1 + p1 + p2;
        hit = (a[15:4] == 12'hFA8) && !m1ack;
        adr = a; data_in = wd; tube_din = td;
        m1_b = !m1ack; rd_b = m1ack || wr; wr_b = m1ack || !wr; ioreq_b = 1'b0;
        released = 1'b0; n = 32; k = 0;
        while (k < n) begin
            @(negedge clk);
            sample(d, k);
            @(posedge clk); #1;
            if (!released && k >= 2 && tr_ctl[k][3]) begin
                ioreq_b = 1'b1; rd_b = 1'b1; wr_b = 1'b1; m1_b = 1'b1;
                released = 1'b1;
                n = (k + 1 + tail > 32) ? 32 : k + 1 + tail;
            end
            k++;
        end
        if (!released) begin
            ioreq_b = 1'b1; rd_b = 1'b1; wr_b = 1'b1; m1_b = 1'b1;
            tests_run++; tests_failed++;
            $display("FAIL %s wait_timeout: WAIT_B still low after 32 cycles, required high at cycle %0d", name, t + 1);
        end
        for (int i = 0; i < n; i++) begin
            in_cyc = hit && i >= 1 && i <= t;
            e_doe  = hit && wr && i >= 1 + p1 && i <= t;
            e_ctl  = {!in_cyc,
                      hit && i >= 1 + p1 && i <= p1 + p2,
                      !(hit && tr_io[i] && i <= t),
                      in_cyc ? !wr : 1'b1,
                      e_doe,
                      hit && !wr && i >= t && tr_io[i]};
            tests_run++;
            if (tr_ctl[i] !== e_ctl) begin
                tests_failed++;
                $display("FAIL %s ctl cycle %0d: got %b required %b (cs_b,phi2,wait_b,rnw,doe,data_oe)",
                         name, i, tr_ctl[i], e_ctl);
            end
            if (in_cyc) begin
                tests_run++;
                if (tr_adr[i] !== a[2:0]) begin
                    tests_failed++;
                    $display("FAIL %s tube_adr cycle %0d: got %0h required %0h", name, i, tr_adr[i], a[2:0]);
                end
            end
            if (e_doe) begin
                tests_run++;
                if (tr_dout[i] !== wd) begin
                    tests_failed++;
                    $display("FAIL %s tube_dout cycle %0d: got %0h required %0h", name, i, tr_dout[i], wd);
                end
            end
            if (hit && !wr && i >= t) begin
                tests_run++;
                if (tr_rdata[i] !== td) begin
                    tests_failed++;
                    $display("FAIL %s data_out cycle %0d: got %0h required %0h", name, i, tr_rdata[i], td);
                end
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            tests_run++;
            if ({tube_cs_b[d], tube_phi2[d], wait_b[d], tube_rnw[d], tube_doe[d], data_oe[d], int_oe[d]} !== 7'b1011000) begin
                tests_failed++;
                $display("FAIL reset ctl dut%0d: got %b required 1011000",
                         d, {tube_cs_b[d], tube_phi2[d], wait_b[d], tube_rnw[d], tube_doe[d], data_oe[d], int_oe[d]});
            end
            tests_run++;
            if ({tube_adr[d], tube_dout[d], data_out[d]} !== 19'd0) begin
                tests_failed++;
                $display("FAIL reset data dut%0d: got adr %0h dout %0h data_out %0h required 0/0/0",
                         d, tube_adr[d], tube_dout[d], data_out[d]);
            end
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write();
        run_access(0, 16'hFA85, 1'b1, 1'b0, 8'h5A, 8'h00, 5, "write_fa85");
    endtask

    task automatic test_read();
        run_access(0, 16'hFA80, 1'b0, 1'b0, 8'h00, 8'hA3, 5, "read_fa80");
    endtask

    task automatic test_non_hit();
        run_access(0, 16'hFA90, 1'b0, 1'b0, 8'h00, 8'h11, 3, "nonhit_fa90");
        run_access(1, 16'hFA90, 1'b1, 1'b0, 8'h22, 8'h00, 3, "nonhit_fa90_wr");
        run_access(0, 16'hFA80, 1'b0, 1'b1, 8'h00, 8'h33, 3, "intack_fa80");
    endtask

    task automatic test_alt_timing();
        run_access(1, 16'hFA87, 1'b1, 1'b0, 8'hC6, 8'h00, 3, "alt_write");
        run_access(1, 16'hFA8C, 1'b0, 1'b0, 8'h00, 8'h6E, 3, "alt_read");
    endtask

    task automatic test_back_to_back();
        run_access(1, 16'hFA81, 1'b0, 1'b0, 8'h00, 8'h95, 1, "b2b_in1");
        run_access(1, 16'hFA82, 1'b0, 1'b0, 8'h00, 8'h4B, 1, "b2b_in2");
        run_access(0, 16'hFA83, 1'b0, 1'b0, 8'h00, 8'hE1, 1, "b2b_in3");
        run_access(0, 16'hFA84, 1'b1, 1'b0, 8'h78, 8'h00, 3, "b2b_out4");
    endtask

    task automatic test_reset_mid_cycle();
        adr = 16'hFA83; data_in = 8'h00; tube_din = 8'h3C;
        m1_b = 1'b1; rd_b = 1'b0; wr_b = 1'b1; ioreq_b = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (tube_phi2 !== 2'b11) begin
            tests_failed++;
            $display("FAIL rst_mid strobe_phase: got phi2 %b required 11", tube_phi2);
        end
        resetn = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            tests_run++;
            if ({tube_cs_b[d], tube_phi2[d], wait_b[d], tube_rnw[d], tube_doe[d], data_oe[d], int_oe[d],
                 tube_adr[d], tube_dout[d], data_out[d]} !== {7'b1011000, 19'd0}) begin
                tests_failed++;
                $display("FAIL rst_mid outputs dut%0d: got ctl %b adr %0h dout %0h data_out %0h required 1011000/0/0/0",
                         d, {tube_cs_b[d], tube_phi2[d], wait_b[d], tube_rnw[d], tube_doe[d], data_oe[d], int_oe[d]},
                         tube_adr[d], tube_dout[d], data_out[d]);
            end
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests_run++;
            if ({tube_cs_b, wait_b} !== 4'b1111) begin
                tests_failed++;
                $display("FAIL rst_mid unarmed cycle %0d: got cs_b %b wait_b %b required 11 11", k, tube_cs_b, wait_b);
            end
            @(posedge clk); #1;
        end
        ioreq_b = 1'b1; rd_b = 1'b1;
        @(posedge clk); #1;
        run_access(0, 16'hFA83, 1'b0, 1'b0, 8'h00, 8'h3C, 3, "rst_mid_next");
    endtask

    task automatic test_interrupt();
        int cnt [2];
        int first [2];
        cnt = '{0, 0};
        first = '{-1, -1};
        tube_int_b = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (int_oe[d]) begin
                    cnt[d]++;
                    if (first[d] < 0) first[d] = k;
                end
            end
            @(posedge clk); #1;
            if (k == 4) tube_int_b = 1'b1;
        end
        for (int d = 0; d < 2; d++) begin
            tests_run++;
            if (cnt[d] != 5) begin
                tests_failed++;
                $display("FAIL int_width dut%0d: got %0d cycles required 5", d, cnt[d]);
            end
            tests_run++;
            if (first[d] < 2 || first[d] > 3) begin
                tests_failed++;
                $display("FAIL int_latency dut%0d: got %0d required 2..3", d, first[d]);
            end
        end
    endtask

    task automatic test_random();
        int d, sel, tail;
        bit wr, m1;
        logic [15:0] a;
        for (int i = 0; i < 24; i++) begin
            d    = $urandom_range(0, 1);
            sel  = $urandom_range(0, 9);
            wr   = 1'($urandom_range(0, 1));
            tail = $urandom_range(1, 3);
            m1   = 1'b0;
            a    = 16'($urandom);
            if (sel < 7) begin
                a = {12'hFA8, a[3:0]};
            end else if (sel == 7) begin
                if (a[15:4] == 12'hFA8) a = a ^ 16'h0100;
            end else if (sel == 8) begin
                a  = {12'hFA8, a[3:0]};
                m1 = 1'b1;
            end
            run_access(d, a, wr, m1, 8'($urandom), 8'($urandom), tail, $sformatf("rand%0d", i));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0; adr = '0; ioreq_b = 1'b1; rd_b = 1'b1; wr_b = 1'b1; m1_b = 1'b1;
        data_in = '0; tube_din = '0; tube_int_b = 1'b1;
        test_reset();
        test_write();
        test_read();
        test_non_hit();
        test_alt_timing();
        test_back_to_back();
        test_reset_mid_cycle();
        test_interrupt();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
